exp_adder_pipe: RTL and testbench

- Pipelined, parametrised multi-precision exponent/scale adder for the posit multiplier datapath.
- Two independent products (E = A×B, F = C×D) per transaction.
- Per-lane signed exponent sum plus a normalisation carry-in, in 4-, 2- or 1-lane SIMD mode.
- valid/ready handshake on both sides; sits between the posit decoders and the mantissa-product normaliser.

---
 rtl/posit_fma_pkg.sv | 32 +++
 rtl/exp_lane_add.sv | 20 ++
 rtl/exp_adder_pipe.sv | 165 ++++++++++++++++
 tb/tb_exp_adder_pipe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_fma_pkg.sv
// ---------------------------------------------------------------------------
// posit_fma_pkg
// Shared definitions for the posit FMA datapath.
//   MODE_4L / MODE_2L / MODE_1L : SIMD lane-split encodings (2'b11 acts as 4L)
//   EXP_OUT_EXTRA               : extra output bits over the packed input width
//   exp_out_width()             : packed exponent-sum width for a given W
//   lane_count()                : number of active lanes for a mode
// ---------------------------------------------------------------------------
package posit_fma_pkg;

  localparam logic [1:0] MODE_4L = 2'b00;
  localparam logic [1:0] MODE_2L = 2'b01;
  localparam logic [1:0] MODE_1L = 2'b10;

  // One guard bit per lane in the widest (4-lane) split.
  localparam int unsigned EXP_OUT_EXTRA = 32'd4;

  function automatic int unsigned exp_out_width(input int unsigned w);
    return w + EXP_OUT_EXTRA;
  endfunction

  function automatic logic [2:0] lane_count(input logic [1:0] mode);
    logic [2:0] n;
    case (mode)
      MODE_2L: n = 3'd2;
      MODE_1L: n = 3'd1;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/exp_lane_add.sv
// ---------------------------------------------------------------------------
// exp_lane_add
// One signed exponent lane: sum = sext(a) + sext(b) + cin, WL+1 bits wide.
// The extra bit makes overflow impossible (range [-2^WL, 2^WL-1]).
//   a, b : WL-bit two's-complement exponents
//   cin  : normalisation carry-in (+1)
//   sum  : WL+1-bit signed result
// ---------------------------------------------------------------------------
module exp_lane_add #(
  parameter int unsigned WL = 4
) (
  input  logic [WL-1:0] a,
  input  logic [WL-1:0] b,
  input  logic          cin,
  output logic [WL:0]   sum
);

  assign sum = {a[WL-1], a} + {b[WL-1], b} + {{WL{1'b0}}, cin};

endmodule

// File: rtl/exp_adder_pipe.sv
// ---------------------------------------------------------------------------
// exp_adder_pipe
// Pipelined SIMD exponent adder for two products (E = A*B, F = C*D).
// All lane arithmetic is done ahead of stage 0; later stages only delay the
// result bundle {mode, s_E, s_F, exp_E, exp_F}. Elastic valid/ready pipeline
// that fills bubbles and sustains one transaction per cycle.
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_valid / in_ready    : upstream handshake
//   mode                   : 00/11 four lanes, 01 two lanes, 10 one lane
//   s_A..s_D, exp_A..exp_D : per-lane signs and packed exponents
//   inc_E, inc_F           : per-lane +1 carry-ins
//   out_valid / out_ready  : downstream handshake
//   mode_o, exp_E, exp_F, s_E, s_F : result bundle
// Optional: define EXP_ADDER_PIPE_STALL_CNT_EN to add stall_cnt[15:0], the
// saturating count of cycles spent with out_valid=1 and out_ready=0.
// ---------------------------------------------------------------------------
module exp_adder_pipe
  import posit_fma_pkg::*;
#(
  parameter int unsigned W   = 16,
  parameter int unsigned LAT = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     mode,
  input  logic [3:0]     s_A,
  input  logic [3:0]     s_B,
  input  logic [3:0]     s_C,
  input  logic [3:0]     s_D,
  input  logic [W-1:0]   exp_A,
  input  logic [W-1:0]   exp_B,
  input  logic [W-1:0]   exp_C,
  input  logic [W-1:0]   exp_D,
  input  logic [3:0]     inc_E,
  input  logic [3:0]     inc_F,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [1:0]     mode_o,
  output logic [W+3:0]   exp_E,
  output logic [W+3:0]   exp_F,
  output logic [3:0]     s_E,
  output logic [3:0]     s_F
`ifdef EXP_ADDER_PIPE_STALL_CNT_EN
  ,
  output logic [15:0]    stall_cnt
`endif
);

  localparam int unsigned Q  = W / 4;
  localparam int unsigned H  = W / 2;
  localparam int unsigned OW = exp_out_width(W);
  localparam int unsigned BW = 2 + 4 + 4 + 2 * OW;

  logic [OW-1:0] e4_s, f4_s;
  logic [W+1:0]  e2_s, f2_s;
  logic [W:0]    e1_s, f1_s;
  logic [OW-1:0] e_pk_s, f_pk_s;
  logic [BW-1:0] in_bundle_s;
  logic [LAT-1:0] adv_s;
  logic [LAT-1:0] v_r;
  logic [BW-1:0]  data_r [LAT];

  // All three lane splits are computed in parallel; mode only picks one.
  for (genvar k = 0; k < 4; k++) begin : g_l4
    exp_lane_add #(.WL(Q)) u_e (
      .a(exp_A[Q*k +: Q]), .b(exp_B[Q*k +: Q]), .cin(inc_E[k]),
      .sum(e4_s[(Q+1)*k +: Q+1]));
    exp_lane_add #(.WL(Q)) u_f (
      .a(exp_C[Q*k +: Q]), .b(exp_D[Q*k +: Q]), .cin(inc_F[k]),
      .sum(f4_s[(Q+1)*k +: Q+1]));
  end

  for (genvar k = 0; k < 2; k++) begin : g_l2
    exp_lane_add #(.WL(H)) u_e (
      .a(exp_A[H*k +: H]), .b(exp_B[H*k +: H]), .cin(inc_E[k]),
      .sum(e2_s[(H+1)*k +: H+1]));
    exp_lane_add #(.WL(H)) u_f (
      .a(exp_C[H*k +: H]), .b(exp_D[H*k +: H]), .cin(inc_F[k]),
      .sum(f2_s[(H+1)*k +: H+1]));
  end

  exp_lane_add #(.WL(W)) u_e1 (.a(exp_A), .b(exp_B), .cin(inc_E[0]), .sum(e1_s));
  exp_lane_add #(.WL(W)) u_f1 (.a(exp_C), .b(exp_D), .cin(inc_F[0]), .sum(f1_s));

  // Pack the lane sums selected by mode into the W+4 output format.
  always_comb begin
    e_pk_s = e4_s;
    f_pk_s = f4_s;
    case (lane_count(mode))
      3'd2: begin
        e_pk_s = {2'b00, e2_s};
        f_pk_s = {2'b00, f2_s};
      end
      3'd1: begin
        e_pk_s = {{3{e1_s[W]}}, e1_s};
        f_pk_s = {{3{f1_s[W]}}, f1_s};
      end
      default: begin
        e_pk_s = e4_s;
        f_pk_s = f4_s;
      end
    endcase
  end

  assign in_bundle_s = {mode, s_A ^ s_B, s_C ^ s_D, e_pk_s, f_pk_s};

  // Stage i may move when out_ready is high or any stage from i to the end
  // is empty: that is the unrolled form of "v[i]=0 or stage i+1 advances",
  // which is what collapses bubbles in the same cycle.
  for (genvar i = 0; i < LAT; i++) begin : g_adv
    assign adv_s[i] = out_ready | ~(&v_r[LAT-1:i]);
  end

  assign in_ready = adv_s[0];

  // Pipeline valid bits and data bundle; data loads only with valid data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        v_r[i]    <= 1'b0;
        data_r[i] <= '0;
      end
    end else begin
      if (adv_s[0]) begin
        v_r[0] <= in_valid;
        if (in_valid) begin
          data_r[0] <= in_bundle_s;
        end
      end
      for (int i = 1; i < LAT; i++) begin
        if (adv_s[i]) begin
          v_r[i] <= v_r[i-1];
          if (v_r[i-1]) begin
            data_r[i] <= data_r[i-1];
          end
        end
      end
    end
  end

  assign out_valid = v_r[LAT-1];
  assign mode_o    = data_r[LAT-1][BW-1 -: 2];
  assign s_E       = data_r[LAT-1][BW-3 -: 4];
  assign s_F       = data_r[LAT-1][BW-7 -: 4];
  assign exp_E     = data_r[LAT-1][2*OW-1 -: OW];
  assign exp_F     = data_r[LAT-1][OW-1 -: OW];

`ifdef EXP_ADDER_PIPE_STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of cycles where a result waits on downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 16'h0000;
    end else if (v_r[LAT-1] && !out_ready && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_exp_adder_pipe.sv
module tb_exp_adder_pipe;

  localparam int W   = 16;
  localparam int LAT = 2;
  localparam int OW  = W + 4;

  typedef struct packed {
    logic [1:0]    mode;
    logic [3:0]    se;
    logic [3:0]    sf;
    logic [OW-1:0] ee;
    logic [OW-1:0] ef;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [1:0] mode, mode_o;
  logic [3:0] s_A, s_B, s_C, s_D, inc_E, inc_F, s_E, s_F;
  logic [W-1:0] exp_A, exp_B, exp_C, exp_D;
  logic [OW-1:0] exp_E, exp_F;
`ifdef EXP_ADDER_PIPE_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  exp_adder_pipe #(.W(W), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .s_A(s_A), .s_B(s_B), .s_C(s_C), .s_D(s_D),
    .exp_A(exp_A), .exp_B(exp_B), .exp_C(exp_C), .exp_D(exp_D),
    .inc_E(inc_E), .inc_F(inc_F), .out_valid(out_valid), .out_ready(out_ready),
    .mode_o(mode_o), .exp_E(exp_E), .exp_F(exp_F), .s_E(s_E), .s_F(s_F)
`ifdef EXP_ADDER_PIPE_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  res_t sb_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_pop = 0;
  logic stall_hold = 1'b0;
  res_t held;
  logic [15:0] model_stall = 16'h0000;

  // Reference: lanes as plain signed integers, repacked at (w+1)-bit stride.
  function automatic logic [OW-1:0] ref_sum(logic [1:0] m, logic [W-1:0] a,
                                            logic [W-1:0] b, logic [3:0] inc);
    int nl, w;
    longint av, bv, s, msk;
    logic [OW-1:0] r;
    nl = (m == 2'b01) ? 2 : (m == 2'b10) ? 1 : 4;
    w = W / nl;
    r = '0;
    for (int k = 0; k < nl; k++) begin
      msk = (longint'(1) << w) - 1;
      av = (longint'(a) >> (w * k)) & msk;
      bv = (longint'(b) >> (w * k)) & msk;
      if (av >= (longint'(1) << (w - 1))) av = av - (longint'(1) << w);
      if (bv >= (longint'(1) << (w - 1))) bv = bv - (longint'(1) << w);
      s = av + bv + longint'(inc[k]);
      if (nl == 1) r = OW'(s);
      else r = r | OW'((s & ((longint'(1) << (w + 1)) - 1)) << ((w + 1) * k));
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, got, req);
    end
  endtask

  // Scoreboard producer: every accepted transaction gets its expected result.
  always @(negedge clk) begin
    res_t e;
    if (rst_n && in_valid && in_ready) begin
      e.mode = mode;
      e.se = s_A ^ s_B;
      e.sf = s_C ^ s_D;
      e.ee = ref_sum(mode, exp_A, exp_B, inc_E);
      e.ef = ref_sum(mode, exp_C, exp_D, inc_F);
      sb_q.push_back(e);
    end
  end

  // Monitor: compare emitted results in order and check hold-while-stalled.
  always @(negedge clk) begin
    res_t cur, e;
    cur = {mode_o, s_E, s_F, exp_E, exp_F};
    if (!rst_n) begin
      stall_hold = 1'b0;
      model_stall = 16'h0000;
    end else begin
      if (stall_hold) begin
        n_cmp++;
        if (!out_valid || cur !== held) begin
          n_err++;
          $display("FAIL hold_stable: got valid=%b data=%h, required valid=1 data=%h",
                   out_valid, cur, held);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        n_pop++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: got %h, required no output", cur);
        end else begin
          e = sb_q.pop_front();
          if (cur !== e) begin
            n_err++;
            $display("FAIL sb_result: got %h, required %h", cur, e);
          end
        end
      end
      stall_hold = out_valid && !out_ready;
      held = cur;
      if (stall_hold && model_stall != 16'hFFFF) model_stall = model_stall + 16'h0001;
    end
  end

  task automatic rand_ops();
    mode = 2'($urandom_range(0, 3));
    exp_A = W'($urandom); exp_B = W'($urandom);
    exp_C = W'($urandom); exp_D = W'($urandom);
    s_A = 4'($urandom); s_B = 4'($urandom); s_C = 4'($urandom); s_D = 4'($urandom);
    inc_E = 4'($urandom); inc_F = 4'($urandom);
  endtask

  // Issue one transaction with out_ready=1, check latency and single pulse.
  task automatic run_one(input string nm, input logic [1:0] m,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] d,
                         input logic [3:0] sa, input logic [3:0] sb,
                         input logic [3:0] ie, input logic [3:0] jf,
                         input logic [OW-1:0] req_e, input logic [OW-1:0] req_f,
                         input logic [3:0] req_se);
    int cyc;
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; mode = m;
    exp_A = a; exp_B = b; exp_C = c; exp_D = d;
    s_A = sa; s_B = sb; s_C = 4'h0; s_D = 4'h0; inc_E = ie; inc_F = jf;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, "_latency"}, 64'(cyc), 64'(LAT));
    chk({nm, "_exp_E"}, 64'(exp_E), 64'(req_e));
    chk({nm, "_exp_F"}, 64'(exp_F), 64'(req_f));
    chk({nm, "_s_E"}, 64'(s_E), 64'(req_se));
    chk({nm, "_mode_o"}, 64'(mode_o), 64'(m));
    @(posedge clk); #1;
    chk({nm, "_pulse"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int acc, c, start_pop, seen;
    logic saw_block;
    in_valid = 1'b0; out_ready = 1'b0;
    mode = 2'b00; exp_A = '0; exp_B = '0; exp_C = '0; exp_D = '0;
    s_A = 4'h0; s_B = 4'h0; s_C = 4'h0; s_D = 4'h0; inc_E = 4'h0; inc_F = 4'h0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_exp_E", 64'(exp_E), 64'd0);
    chk("rst_exp_F", 64'(exp_F), 64'd0);
    chk("rst_s_E_mode_o", 64'({s_E, s_F, mode_o}), 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed cases from hand-derived lane values.
    run_one("m00", 2'b00, 16'h7F81, 16'h1111, 16'h0000, 16'h0000, 4'h0, 4'h0,
            4'b0001, 4'b0000, 20'h40323, 20'h00000, 4'h0);
    run_one("m01", 2'b01, 16'h0000, 16'h0000, 16'h80FF, 16'h8001, 4'h0, 4'h0,
            4'b0000, 4'b0000, 20'h00000, 20'h20000, 4'h0);
    run_one("m10", 2'b10, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 4'hA, 4'h3,
            4'b0001, 4'b0000, 20'hFFFFF, 20'h00000, 4'h9);
    run_one("m11", 2'b11, 16'h7F81, 16'h1111, 16'h0000, 16'h0000, 4'h0, 4'h0,
            4'b0001, 4'b0000, 20'h40323, 20'h00000, 4'h0);

    // Back-to-back 8 with a downstream stall in cycles 3..6.
    start_pop = n_pop;
    acc = 0; c = 0; saw_block = 1'b0;
    while (acc < 8 && c < 100) begin
      @(posedge clk); #1;
      out_ready = !(c >= 3 && c <= 6);
      in_valid = 1'b1;
      rand_ops();
      #1;
      if (in_ready) acc++;
      else saw_block = 1'b1;
      c++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    c = 0;
    while (sb_q.size() != 0 && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    chk("stall_in_ready_dropped", 64'(saw_block), 64'd1);
    chk("stall_all_emitted", 64'(n_pop - start_pop), 64'd8);

    // Reset with transactions in flight.
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; rand_ops();
    @(posedge clk); #1;
    rand_ops();
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    sb_q.delete();
    stall_hold = 1'b0;
    model_stall = 16'h0000;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_exp_EF", 64'({exp_E, exp_F}), 64'd0);
`ifdef EXP_ADDER_PIPE_STALL_CNT_EN
    chk("midrst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    @(posedge clk); #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    chk("midrst_no_stale", 64'(seen), 64'd0);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      rand_ops();
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    c = 0;
    while (sb_q.size() != 0 && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("final_sb_empty", 64'(sb_q.size()), 64'd0);
    chk("final_out_valid", 64'(out_valid), 64'd0);
`ifdef EXP_ADDER_PIPE_STALL_CNT_EN
    chk("final_stall_cnt", 64'(stall_cnt), 64'(model_stall));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
